alu_mul_sequencer: RTL and testbench
====================================

// Module: alu_mul_sequencer
// PURPOSE
//  Multi-cycle unsigned multiply controller built on the shared ALU.
//  - Drives the ALU operand and op_sel inputs with shift-add steps, one ALU ADD per cycle.
//  - Sits beside the ALU in the execute stage and returns the low WIDTH bits of the product.
//  - The execute stage stalls on busy and resumes on done.
// PARAMETERS
//  WIDTH   64     operand / product width; must match the ALU data width
//  OP_ADD  4'd2   ALU op_sel encoding for ADD
// PORTS
//  clk           in   1      single clock, rising edge
//  rst           in   1      asynchronous, active-high reset
//  start         in   1      request; sampled only in IDLE
//  multiplicand  in   WIDTH  operand A, latched when start is accepted
//  multiplier    in   WIDTH  operand B, latched when start is accepted
//  busy          out  1      high in RUN and DONE
//  done          out  1      one-cycle pulse in DONE; product is valid
//  product       out  WIDTH  low WIDTH bits of A*B; held until the next accepted start
//  alu_src1      out  WIDTH  to ALU src1 (accumulator)
//  alu_src2      out  WIDTH  to ALU src2 (gated shifted multiplicand)
//  alu_op_sel    out  4      to ALU op_sel; always OP_ADD
//  alu_result    in   WIDTH  from ALU result; combinational, same cycle
// BEHAVIOUR
//  Reset (async, any state)
//   - state=IDLE; busy=0, done=0; product=0.
//   - alu_src1=0, alu_src2=0, alu_op_sel=OP_ADD.
//   - Internal mcand, mplier, acc and count are cleared to 0.
//  State machine: IDLE -> RUN -> DONE -> IDLE
//  IDLE
//   - alu_src1=0, alu_src2=0.
//   - On clock edge with start=1: mcand<=multiplicand, mplier<=multiplier, acc<=0, count<=0; go to RUN.
//   - Otherwise stay in IDLE.
//  RUN, every cycle
//   - alu_src1=acc; alu_src2 = mplier[0] ? mcand : 0.
//   - At the edge: acc<=alu_result; mcand<=mcand<<1 (MSB dropped); mplier<=mplier>>1 (zero fill); count<=count+1.
//   - When count==WIDTH-1 at the edge, product<=alu_result and go to DONE.
//  DONE
//   - done=1 for exactly one cycle; busy=1; alu_src1=0, alu_src2=0.
//   - Unconditional return to IDLE.
//  Latency
//   - Fixed: start accepted at edge E0; WIDTH RUN cycles (edges E1..E_WIDTH).
//   - done is high in the cycle after E_WIDTH, so done is seen WIDTH+1 cycles after start.
//   - There is no early termination, even when the multiplier is 0.
//  start handling
//   - start is ignored in RUN and DONE; operands are not re-latched.
//   - start asserted in the DONE cycle is lost; the requester re-asserts in IDLE.
//  Arithmetic
//   - Unsigned; overflow beyond WIDTH bits is discarded (modulo 2^WIDTH).
//   - The ALU zero flag is not used.
//  Output hold
//   - product changes only at RUN->DONE and at reset.
//   - count is $clog2(WIDTH)+1 bits wide.
// TESTING
//  - rst, start, A=3, B=5 -> done one cycle, WIDTH+1 cycles after start; product=15; busy high for WIDTH+1 cycles.
//  - A=0x1234, B=0 -> product=0 at the same fixed latency; alu_src2=0 every RUN cycle.
//  - A=B=64'hFFFF_FFFF_FFFF_FFFF -> product=64'h1 (wrap-around); latency unchanged.
//  - Run A=7, B=9; pulse start with A=2, B=2 at cycle 10 -> product=63; second request ignored.
//  - Start A=6, B=7; assert rst at cycle 20 -> busy=0, done=0, product=0 immediately (async).
//    Then start A=6, B=7 -> product=42.
//  - Back-to-back: A=2, B=3, then start on the first IDLE cycle after done with A=4, B=5.
//    -> products 6 then 20; alu_op_sel==OP_ADD throughout.

Source files
------------

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle unsigned shift-add multiplier that borrows the shared ALU adder.
// Each RUN cycle issues one ADD: accumulator plus the multiplicand, gated by the
// current multiplier LSB. The low WIDTH bits of the product are returned.
module alu_mul_sequencer #(
  parameter int unsigned WIDTH  = 64,
  parameter logic [3:0]  OP_ADD = 4'd2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] multiplicand_i,
  input  logic [WIDTH-1:0] multiplier_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o,
  output logic [WIDTH-1:0] alu_src1_o,
  output logic [WIDTH-1:0] alu_src2_o,
  output logic [3:0]       alu_op_sel_o,
  input  logic [WIDTH-1:0] alu_result_i
);

  localparam int unsigned   CntW    = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] product_q;
  logic [CntW-1:0]  count_q;
  logic             busy_q;
  logic             done_q;

  // Control FSM and shift-add datapath; busy/done/product are registered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      product_q <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            mcand_q  <= multiplicand_i;
            mplier_q <= multiplier_i;
            acc_q    <= '0;
            count_q  <= '0;
            busy_q   <= 1'b1;
            state_q  <= StRun;
          end
        end
        StRun: begin
          acc_q    <= alu_result_i;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          count_q  <= count_q + 1'b1;
          // Fixed WIDTH iterations; no early exit on a zero multiplier.
          if (count_q == LastCnt) begin
            product_q <= alu_result_i;
            done_q    <= 1'b1;
            state_q   <= StDone;
          end
        end
        StDone: begin
          // start seen here is dropped; requester retries from IDLE.
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  // ALU operands are only non-zero while iterating.
  always_comb begin
    alu_src1_o = '0;
    alu_src2_o = '0;
    if (state_q == StRun) begin
      alu_src1_o = acc_q;
      alu_src2_o = mplier_q[0] ? mcand_q : '0;
    end
  end

  assign alu_op_sel_o = OP_ADD;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign product_o    = product_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Scoreboard bench for alu_mul_sequencer with a behavioural ALU alongside.
module tb_alu_mul_sequencer;

  localparam int unsigned WIDTH  = 64;
  localparam logic [3:0]  OP_ADD = 4'd2;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic [3:0]       op_sel;
  logic [WIDTH-1:0] alu_res;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];
  bit mon_en   = 1'b0;
  bit zero_chk = 1'b0;

  alu_mul_sequencer #(
    .WIDTH (WIDTH),
    .OP_ADD(OP_ADD)
  ) u_dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .multiplicand_i(mcand),
    .multiplier_i  (mplier),
    .busy_o        (busy),
    .done_o        (done),
    .product_o     (product),
    .alu_src1_o    (src1),
    .alu_src2_o    (src2),
    .alu_op_sel_o  (op_sel),
    .alu_result_i  (alu_res)
  );

  // Shared ALU stand-in: only ADD gives a sum, anything else gives garbage.
  assign alu_res = (op_sel == OP_ADD) ? src1 + src2 : src1 - src2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WIDTH-1:0] got,
                     input logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Cycle monitor: op_sel fixed, operands idle outside RUN, gated src2 for B=0.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("op_sel", {60'd0, op_sel}, {60'd0, OP_ADD});
      if (!busy || done) begin
        chk("src1_idle", src1, '0);
        chk("src2_idle", src2, '0);
      end
      if (zero_chk && busy) chk("src2_zero", src2, '0);
    end
  end

  // Issue one multiply; optionally inject a stray start or an async reset
  // at a given cycle count (0 disables). Cycle 1 is the one after acceptance.
  task automatic do_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input int inject_at, input int rst_at);
    int cyc;
    int busy_n;
    logic [WIDTH-1:0] exp;
    @(negedge clk);
    start  = 1'b1;
    mcand  = a;
    mplier = b;
    exp_q.push_back(a * b);
    @(posedge clk);
    #1;
    start  = 1'b0;
    cyc    = 1;
    busy_n = 0;
    while (!done && cyc <= 3 * WIDTH) begin
      if (busy) busy_n++;
      if (cyc == inject_at) begin
        start  = 1'b1;
        mcand  = 64'd2;
        mplier = 64'd2;
      end else begin
        start = 1'b0;
      end
      if (cyc == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_busy", {63'd0, busy}, '0);
        chk("rst_done", {63'd0, done}, '0);
        chk("rst_product", product, '0);
        void'(exp_q.pop_back());
        #1;
        rst = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    if (!done) begin
      chk("done_timeout", {63'd0, done}, 64'd1);
      return;
    end
    busy_n++;
    chk("latency", 64'(cyc), 64'(WIDTH + 1));
    chk("busy_cycles", 64'(busy_n), 64'(WIDTH + 1));
    exp = exp_q.pop_front();
    chk("product", product, exp);
    @(posedge clk);
    #1;
    chk("done_pulse", {63'd0, done}, '0);
    chk("busy_clear", {63'd0, busy}, '0);
    chk("product_hold", product, exp);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    mcand  = '0;
    mplier = '0;
    #12;
    chk("reset_busy", {63'd0, busy}, '0);
    chk("reset_done", {63'd0, done}, '0);
    chk("reset_product", product, '0);
    chk("reset_src1", src1, '0);
    chk("reset_src2", src2, '0);
    chk("reset_op_sel", {60'd0, op_sel}, {60'd0, OP_ADD});
    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);

    do_mul(64'd3, 64'd5, 0, 0);

    zero_chk = 1'b1;
    do_mul(64'h1234, 64'd0, 0, 0);
    zero_chk = 1'b0;

    do_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);

    // Stray start mid-run must not re-latch operands.
    do_mul(64'd7, 64'd9, 10, 0);

    // Async reset mid-run, then a clean retry.
    do_mul(64'd6, 64'd7, 0, 20);
    chk("post_rst_product", product, '0);
    do_mul(64'd6, 64'd7, 0, 0);

    // Back-to-back: second start on the first IDLE cycle after done.
    do_mul(64'd2, 64'd3, 0, 0);
    do_mul(64'd4, 64'd5, 0, 0);

    do_mul(64'hDEAD_BEEF_0000_0001, 64'h0000_0001_0000_0003, 0, 0);

    chk("scoreboard_empty", 64'(exp_q.size()), '0);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
